// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, 2-entry {pc,instr} FIFO, redirect flush; optional FETCH_PERF_EN adds redirect_count.
// Response pushed same cycle, visible next cycle; requests throttle so FIFO occupancy plus outstanding never exceeds 2.
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_en,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           redirect_count
`endif
);

  typedef enum logic [1:0] {RUN, WAIT, DRAIN} state_e;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0] fifo_pc_q    [2];
  logic [DATA_WIDTH-1:0] fifo_instr_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q, count_d;

  logic       rsp_in_wait, pop_raw, accept, push, pop, owed;
  logic [2:0] occ_next;

  assign out_valid     = (count_q != 2'd0);
  assign out_pc        = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
  assign out_instr     = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign imem_req_addr = fetch_pc_q & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // A request still owed after this cycle sends a redirect to DRAIN so its response is dropped.
  always_comb begin
    owed    = accept || ((state_q != RUN) && !imem_rsp_valid);
    state_d = state_q;
    if (redirect_en)                               state_d = owed ? DRAIN : RUN;
    else if (accept)                               state_d = WAIT;
    else if ((state_q != RUN) && imem_rsp_valid)   state_d = RUN;
  end

  // A response arriving in WAIT retires the outstanding request, so the next one may issue that same cycle.
  always_comb begin
    rsp_in_wait    = (state_q == WAIT) && imem_rsp_valid;
    pop_raw        = out_valid && out_ready;
    occ_next       = {1'b0, count_q} + {2'b00, rsp_in_wait} - {2'b00, pop_raw};
    imem_req_valid = rst_n && ((state_q == RUN) || rsp_in_wait) && (occ_next < 3'd2);
    accept         = imem_req_valid && imem_req_ready;
    push           = rsp_in_wait && !redirect_en;
    pop            = pop_raw && !redirect_en;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_en) fetch_pc_d = redirect_pc & ALIGN_MASK;
    else if (accept) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
    count_d = redirect_en ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC & ALIGN_MASK;
      req_pc_q   <= '0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (accept) req_pc_q <= fetch_pc_q;
      if (redirect_en) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          fifo_pc_q[wr_ptr_q]    <= req_pc_q;
          fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
          wr_ptr_q               <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] redirect_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         redirect_count_q <= 32'd0;
    else if (redirect_en && (redirect_count_q != '1))   redirect_count_q <= redirect_count_q + 32'd1;
  end

  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected request addresses and decode outputs are queued by the
// directed stimulus and consumed by a negedge monitor; a small memory model answers each accepted request.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] redirect_count;
`endif

  logic [31:0] exp_addr_q [$];
  out_t        exp_out_q  [$];
  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;

  int          mem_lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  fetch_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .redirect_count (redirect_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise ready until n requests are seen valid, then drop it right after the last acceptance edge.
  task automatic issue(input int n);
    int got = 0;
    int cyc = 0;
    imem_req_ready = 1'b1;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (imem_req_valid) got++;
    end
    @(posedge clk);
    #1;
    imem_req_ready = 1'b0;
    check("issue_count", got, n);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_addr_q.size() != 0 || exp_out_q.size() != 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_addr_left", exp_addr_q.size(), 0);
    check("drain_out_left", exp_out_q.size(), 0);
    step();
  endtask

  function automatic void expect_out(input logic [31:0] pc, input logic [31:0] instr);
    out_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_out_q.push_back(e);
  endfunction

  // Memory: answers each accepted request mem_lat cycles later with data = addr + 0x1000_0000.
  initial begin
    logic        acc_now;
    logic [31:0] addr_now;
    int          lat_now;
    forever begin
      @(negedge clk);
      acc_now  = rst_n && imem_req_valid && imem_req_ready;
      addr_now = imem_req_addr;
      lat_now  = mem_lat;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (acc_now) begin
        mem_busy = 1'b1;
        mem_cnt  = lat_now;
        mem_addr = addr_now;
      end
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_addr + 32'h1000_0000;
          mem_busy       = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        n_acc++;
        if (exp_addr_q.size() == 0) check("req_unexpected", imem_req_addr, 32'hxxxx_xxxx);
        else                        check("req_addr", imem_req_addr, exp_addr_q.pop_front());
      end
      if (out_valid && out_ready && !redirect_en) begin
        if (exp_out_q.size() == 0) begin
          check("out_unexpected", out_pc, 32'hxxxx_xxxx);
        end else begin
          out_t e;
          e = exp_out_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_en    = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h100);

    // Streaming from RESET_PC at one request per cycle
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(32'h100 + 32'(4 * i));
      expect_out(32'h100 + 32'(4 * i), 32'h1000_0100 + 32'(4 * i));
    end
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("tput_req_valid", imem_req_valid, 1);
    end
    step();
    imem_req_ready = 1'b0;
    wait_drain();

    // Backpressure: decode stalled, only two requests may issue
    redirect_en = 1'b1;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    step();
    redirect_en = 1'b0;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    n0 = n_acc;
    imem_req_ready = 1'b1;
    repeat (10) step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    check("bp_req_count", n_acc - n0, 2);
    check("bp_req_valid_low", imem_req_valid, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_head_instr", out_instr, 32'h1000_0000);
    step();
    expect_out(32'h0, 32'h1000_0000);
    expect_out(32'h4, 32'h1000_0004);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_req_valid_on_pop", imem_req_valid, 1);
    wait_drain();

    // Redirect while WAIT: pending response dropped, new target fetched
    mem_lat = 3;
    exp_addr_q.push_back(32'h8);
    issue(1);
    redirect_en = 1'b1;
    redirect_pc = 32'h2003;
    step();
    redirect_en = 1'b0;
    @(negedge clk);
    check("drain_req_addr", imem_req_addr, 32'h2000);
    check("drain_req_valid", imem_req_valid, 0);
    step();
    exp_addr_q.push_back(32'h2000);
    expect_out(32'h2000, 32'h1000_2000);
    issue(1);
    wait_drain();
    mem_lat = 1;

    // Redirect coinciding with a response and a pop
    out_ready = 1'b0;
    exp_addr_q.push_back(32'h2004);
    exp_addr_q.push_back(32'h2008);
    issue(1);
    issue(1);
    redirect_en = 1'b1;
    redirect_pc = 32'h3000;
    out_ready   = 1'b1;
    @(negedge clk);
    check("coinc_pre_out_valid", out_valid, 1);
    check("coinc_pre_rsp_valid", imem_rsp_valid, 1);
    step();
    redirect_en = 1'b0;
    @(negedge clk);
    check("coinc_fifo_empty", out_valid, 0);
    check("coinc_req_addr", imem_req_addr, 32'h3000);
    step();
    exp_addr_q.push_back(32'h3000);
    expect_out(32'h3000, 32'h1000_3000);
    issue(1);
    wait_drain();

    // Fetch PC wraps at the top of the address space
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    expect_out(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    expect_out(32'h0000_0000, 32'h1000_0000);
    issue(2);
    wait_drain();
    @(negedge clk);
    check("wrap_next_addr", imem_req_addr, 32'h4);
    step();

    // Asynchronous reset in WAIT with a filled FIFO; stale response afterwards is ignored
    out_ready = 1'b0;
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    issue(1);
    mem_lat = 3;
    issue(1);
    @(negedge clk);
    check("arst_pre_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", imem_req_valid, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_pc", out_pc, 32'h0);
    check("arst_out_instr", out_instr, 32'h0);
    check("arst_req_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_EN
    check("arst_redirect_count", redirect_count, 32'h0);
`endif
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_valid", imem_req_valid, 1);
    check("post_rst_req_addr", imem_req_addr, 32'h100);
    repeat (4) step();
    @(negedge clk);
    check("stale_rsp_ignored", out_valid, 0);
    step();
    mem_lat = 1;

    // Three redirect cycles
    redirect_en = 1'b1;
    redirect_pc = 32'h40;
    repeat (3) step();
    redirect_en = 1'b0;
    @(negedge clk);
    check("redir_req_addr", imem_req_addr, 32'h40);
`ifdef FETCH_PERF_EN
    check("redirect_count", redirect_count, 32'd3);
`endif

    check("final_addr_q_empty", exp_addr_q.size(), 0);
    check("final_out_q_empty", exp_out_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
